alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Execution controller placed directly upstream of the 4-bit ALU.
//  - Accepts one instruction per handshake and reads operands from a 4-entry register file.
//  - Drives the ALU's A/B/sel inputs from registers.
//  - Captures the ALU's R/flag outputs and writes R back to the register file.
//  - Turns the combinational ALU into a sequenced datapath.
// PARAMETERS
//  DATA_W  4  operand/result width; must match ALU A/B/R width
//  SEL_W   3  ALU opcode width; must match ALU sel width
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       instruction valid
//  in_ready   out  1       controller can accept an instruction
//  in_op      in   SEL_W   ALU opcode, forwarded to alu_sel
//  in_rd      in   2       destination register index
//  in_rs_a    in   2       source register for A
//  in_rs_b    in   2       source register for B (ignored if in_use_imm)
//  in_use_imm in   1       1: B = in_imm
//  in_imm     in   DATA_W  immediate operand
//  alu_a      out  DATA_W  to ALU A
//  alu_b      out  DATA_W  to ALU B
//  alu_sel    out  SEL_W   to ALU sel
//  alu_r      in   DATA_W  from ALU R
//  alu_flag   in   1       from ALU flag
//  done       out  1       one-cycle pulse after write-back
//  flag_q     out  1       ALU flag of last completed instruction
//  dbg_addr   in   2       register read-back address
//  dbg_data   out  DATA_W  regs[dbg_addr], combinational read
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE; regs[0..3]=0; alu_a=alu_b=0; alu_sel=0; done=0; flag_q=0.
//  FSM states: IDLE, ISSUE, WRITE.
//  IDLE:
//  - in_ready=1.
//  - If in_valid at the edge: latch in_rd, latch op to alu_sel.
//  - Latch alu_a=regs[rs_a] and alu_b=use_imm?imm:regs[rs_b]; go to ISSUE.
//  ISSUE:
//  - in_ready=0. ALU inputs hold stable for a full cycle while the ALU settles.
//  - Go to WRITE unconditionally.
//  WRITE:
//  - in_ready=0. At the edge: regs[rd]<=alu_r, flag_q<=alu_flag, done<=1; go to IDLE.
//  Latency and throughput:
//  - Accept edge N; write-back edge N+2; done high in cycle N+2..N+3.
//  - The next accept is possible at edge N+3, giving 1 instruction per 3 cycles.
//  - done is registered, high exactly one cycle, and coincides with in_ready=1.
//  Output holding:
//  - alu_a/b/sel are registered and hold their last values in IDLE.
//  - They change only on accept.
//  Operand capture and hazards:
//  - Operands are sampled at accept, so rd==rs_a or rd==rs_b is safe.
//  - Back-to-back dependent instructions see the updated value; write completes before the next accept.
//  Handshake:
//  - in_valid while in_ready=0 is ignored; nothing is queued.
//  - The source must hold its instruction until it sees in_ready.
//  Width:
//  - alu_r is stored as-is, DATA_W bits.
//  - The controller performs no arithmetic; carry/compare info reaches flag_q only via alu_flag.
//  - flag_q changes only in WRITE.
//  dbg_data is a pure combinational read. It reflects a write in the cycle after the WRITE edge.
//  Reset mid-operation (ISSUE or WRITE):
//  - The instruction is aborted and no write-back occurs.
//  - done stays 0; all regs return to 0.
// TESTING (bench wires the team ALU; sel 000=add)
//  1. Reset then release -> dbg_data=0 for addr 0..3; in_ready=1, done=0, flag_q=0.
//  2. Immediate chain, each waiting for done:
//     - op=000 rd=1 rs_a=0 imm=3 use_imm=1 -> r1=3.
//     - then op=000 rd=2 rs_a=0 imm=2 use_imm=1 -> r2=2.
//     - then op=000 rd=3 rs_a=1 rs_b=2 -> alu_a=3, alu_b=2, r3=5.
//     - done is seen 2 cycles after each accept.
//  3. Self-dependent chain:
//     - op=000 rd=1 rs_a=1 imm=1 issued 4 times starting from r1=3 -> r1=7.
//     - rs_b=1 must not be read when use_imm=1.
//  4. in_valid held high through ISSUE/WRITE -> exactly one accept per 3 cycles; no double write.
//  5. Assert rst_n low during ISSUE of rd=2 after r2=5 -> r2=0; done never pulses; alu_a/b/sel=0.
//  6. Wrap: r1=15, op=000 imm=1 -> r1=0; flag_q equals ALU flag for 15+1 (checked vs ALU model).

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execution controller that sequences a combinational 4-bit ALU.
// Operands come from a 4-entry register file, and the ALU result is written back to it.
module alu_exec_ctrl #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_op,
  input  logic [1:0]        in_rd,
  input  logic [1:0]        in_rs_a,
  input  logic [1:0]        in_rs_b,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_flag,
  output logic              done,
  output logic              flag_q,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [1:0]        rd_q;
  logic              accept;
  logic [DATA_W-1:0] regs [4];

  assign in_ready = (state == IDLE);
  assign accept   = in_ready & in_valid;
  assign dbg_data = regs[dbg_addr];

  // ISSUE exists only to give the external ALU a full cycle to settle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands are captured at accept, so rd may alias rs_a or rs_b without a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      alu_a   <= regs[in_rs_a];
      alu_b   <= in_use_imm ? in_imm : regs[in_rs_b];
      alu_sel <= in_op;
      rd_q    <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (state == WRITE) begin
      regs[rd_q] <= alu_r;
    end
  end

  // done is high in the cycle after write-back, which is always an IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      done <= (state == WRITE);
      if (state == WRITE) begin
        flag_q <= alu_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural model of the team ALU wired in.
// In that model, sel 000 is add and the flag is the carry out.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs_a;
  logic [1:0] in_rs_b;
  logic       in_use_imm;
  logic [3:0] in_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_r;
  logic       alu_flag;
  logic       done;
  logic       flag_q;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(4), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_r(alu_r), .alu_flag(alu_flag),
    .done(done), .flag_q(flag_q),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Team ALU stand-in: the flag is the carry for add and the borrow for sub.
  logic [4:0] alu_sum;
  always_comb begin
    alu_r    = '0;
    alu_flag = 1'b0;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_sel)
      3'b000: begin alu_r = alu_sum[3:0]; alu_flag = alu_sum[4]; end
      3'b001: begin alu_r = alu_a - alu_b; alu_flag = (alu_a < alu_b); end
      3'b010: alu_r = alu_a & alu_b;
      3'b011: alu_r = alu_a | alu_b;
      3'b100: alu_r = alu_a ^ alu_b;
      3'b101: alu_r = ~alu_a;
      3'b110: alu_r = alu_a << 1;
      default: alu_flag = (alu_a == alu_b);
    endcase
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkReg(input string tag, input logic [1:0] addr, input logic [3:0] expected);
    dbg_addr = addr;
    #1;
    checkOutput(tag, {4'h0, dbg_data}, {4'h0, expected});
  endtask

  // Present one instruction, wait (bounded) for it to be accepted, then drop in_valid.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs_a,
                               input logic [1:0] rs_b, input logic use_imm, input logic [3:0] imm);
    int waited = 0;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs_a = rs_a; in_rs_b = rs_b;
    in_use_imm = use_imm; in_imm = imm; in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", {7'h0, in_ready}, 8'h01);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // After accept edge N, done must be low after N and N+1, then high after N+2.
  task automatic finishInstr(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done_n1"}, {7'h0, done}, 8'h00);
    checkOutput({tag, "_ready_n1"}, {7'h0, in_ready}, 8'h00);
    @(negedge clk);
    checkOutput({tag, "_done_n2"}, {7'h0, done}, 8'h00);
    @(negedge clk);
    checkOutput({tag, "_done_n3"}, {7'h0, done}, 8'h01);
    checkOutput({tag, "_ready_n3"}, {7'h0, in_ready}, 8'h01);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs_a = '0; in_rs_b = '0;
    in_use_imm = 1'b0; in_imm = '0; dbg_addr = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) checkReg($sformatf("reset_r%0d", i), 2'(i), 4'h0);
    checkOutput("reset_ready", {7'h0, in_ready}, 8'h01);
    checkOutput("reset_done", {7'h0, done}, 8'h00);
    checkOutput("reset_flag", {7'h0, flag_q}, 8'h00);
    checkOutput("reset_sel", {5'h0, alu_sel}, 8'h00);

    // Immediate chain, then a register-register add.
    applyStimulus(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3);
    finishInstr("imm1");
    checkReg("imm1_r1", 2'd1, 4'd3);
    applyStimulus(3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 4'd2);
    finishInstr("imm2");
    checkReg("imm2_r2", 2'd2, 4'd2);
    applyStimulus(3'b000, 2'd3, 2'd1, 2'd2, 1'b0, 4'd9);
    @(negedge clk);
    checkOutput("rr_alu_a", {4'h0, alu_a}, 8'd3);
    checkOutput("rr_alu_b", {4'h0, alu_b}, 8'd2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rr_done", {7'h0, done}, 8'h01);
    checkReg("rr_r3", 2'd3, 4'd5);
    checkOutput("rr_hold_a", {4'h0, alu_a}, 8'd3);

    // Self-dependent chain; rs_b points at r2 (2), so alu_b must still be the immediate 1.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b000, 2'd1, 2'd1, 2'd2, 1'b1, 4'd1);
      @(negedge clk);
      checkOutput($sformatf("self%0d_alu_a", k), {4'h0, alu_a}, 8'(3 + k));
      checkOutput($sformatf("self%0d_alu_b", k), {4'h0, alu_b}, 8'd1);
      @(negedge clk);
      @(negedge clk);
    end
    checkReg("self_r1", 2'd1, 4'd7);

    // in_valid held high for nine edges: accepts at 0, 3, and 6 give r2 = 2 + 3.
    @(negedge clk);
    in_op = 3'b000; in_rd = 2'd2; in_rs_a = 2'd2; in_rs_b = 2'd0; in_use_imm = 1'b1; in_imm = 4'd1;
    in_valid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    in_valid = 1'b0;
    checkOutput("hold_pulses", 8'(pulses), 8'd3);
    checkOutput("hold_ready", {7'h0, in_ready}, 8'h01);
    checkReg("hold_r2", 2'd2, 4'd5);

    // Reset during ISSUE aborts the instruction and clears everything.
    applyStimulus(3'b001, 2'd2, 2'd2, 2'd0, 1'b1, 4'd4);
    @(negedge clk);
    checkOutput("abort_pre_sel", {5'h0, alu_sel}, 8'd1);
    checkOutput("abort_pre_a", {4'h0, alu_a}, 8'd5);
    rst_n = 1'b0;
    #1;
    checkReg("abort_r2", 2'd2, 4'd0);
    checkReg("abort_r1", 2'd1, 4'd0);
    checkOutput("abort_a", {4'h0, alu_a}, 8'd0);
    checkOutput("abort_b", {4'h0, alu_b}, 8'd0);
    checkOutput("abort_sel", {5'h0, alu_sel}, 8'd0);
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_pulses", 8'(pulses), 8'd0);
    checkReg("abort_after_r2", 2'd2, 4'd0);

    // Wrap: r1 = 15, then 15 + 1 gives 0 with carry set.
    applyStimulus(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd15);
    finishInstr("wrap_load");
    checkReg("wrap_r1_15", 2'd1, 4'd15);
    checkOutput("wrap_flag_pre", {7'h0, flag_q}, 8'h00);
    applyStimulus(3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 4'd1);
    @(negedge clk);
    checkOutput("wrap_flag_issue", {7'h0, flag_q}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_done", {7'h0, done}, 8'h01);
    checkReg("wrap_r1_0", 2'd1, 4'd0);
    checkOutput("wrap_flag", {7'h0, flag_q}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
